// File: rtl/prog_loader.sv
// prog_loader: byte-stream program loader for the BIP processor.
// Receives a framed byte stream (0xA5, LEN_HI, LEN_LO, N x {hi,lo}, CHK),
// writes each assembled 16-bit word into program memory and, when the XOR
// checksum of the word bytes matches, releases the processor.
//
// Ports:
//   Clk       - system clock, rising edge
//   Reset     - asynchronous active-low reset
//   Rx_Data   - received byte, qualified by Rx_Valid
//   Rx_Valid  - one-cycle strobe per received byte
//   Wr_En     - program memory write strobe (one cycle per word)
//   Wr_Addr   - program memory write address
//   Wr_Data   - program memory write data (holds last written word)
//   Busy      - a frame is being received
//   Cpu_Run   - processor run enable, sticky until Reset
//   Error     - last frame rejected; cleared by the next header byte
module prog_loader #(
  parameter int unsigned addr_bus  = 11,
  parameter int unsigned data_size = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [7:0]           Rx_Data,
  input  logic                 Rx_Valid,
  output logic                 Wr_En,
  output logic [addr_bus-1:0]  Wr_Addr,
  output logic [data_size-1:0] Wr_Data,
  output logic                 Busy,
  output logic                 Cpu_Run,
  output logic                 Error
);

  localparam int unsigned IDX_W     = addr_bus + 1;
  localparam int unsigned MAX_WORDS = 32'd1 << addr_bus;
  localparam logic [7:0]  HEADER    = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_CHECK,
    S_RUN,
    S_ERROR
  } state_t;

  state_t                 state_q, state_d;
  logic [15:0]            len_q, len_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [7:0]             chk_q, chk_d;
  logic [7:0]             hi_q, hi_d;
  logic                   wr_en_q, wr_en_d;
  logic [addr_bus-1:0]    wr_addr_q, wr_addr_d;
  logic [data_size-1:0]   wr_data_q, wr_data_d;
  logic                   busy_q, busy_d;
  logic                   run_q, run_d;
  logic                   err_q, err_d;
  logic [15:0]            len_new;
  logic [IDX_W-1:0]       idx_inc;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    chk_d     = chk_q;
    hi_d      = hi_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    len_new   = {len_q[15:8], Rx_Data};
    idx_inc   = idx_q + IDX_W'(1);

    if (Rx_Valid) begin
      case (state_q)
        S_IDLE: begin
          if (Rx_Data == HEADER) state_d = S_LEN_HI;
        end
        S_LEN_HI: begin
          len_d[15:8] = Rx_Data;
          state_d     = S_LEN_LO;
        end
        S_LEN_LO: begin
          len_d[7:0] = Rx_Data;
          idx_d      = '0;
          chk_d      = '0;
          if (len_new == 16'd0 || 32'(len_new) > MAX_WORDS) state_d = S_ERROR;
          else                                              state_d = S_DATA_HI;
        end
        S_DATA_HI: begin
          hi_d    = Rx_Data;
          chk_d   = chk_q ^ Rx_Data;
          state_d = S_DATA_LO;
        end
        S_DATA_LO: begin
          chk_d     = chk_q ^ Rx_Data;
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q[addr_bus-1:0];
          wr_data_d = {hi_q, Rx_Data};
          idx_d     = idx_inc;
          // Index is one bit wider than the address so N = 2**addr_bus
          // terminates instead of wrapping back to zero.
          if (32'(idx_inc) == 32'(len_q)) state_d = S_CHECK;
          else                            state_d = S_DATA_HI;
        end
        S_CHECK: begin
          if (Rx_Data == chk_q) state_d = S_RUN;
          else                  state_d = S_ERROR;
        end
        S_RUN: begin
          state_d = S_RUN;
        end
        S_ERROR: begin
          if (Rx_Data == HEADER) state_d = S_LEN_HI;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Status outputs are decoded from the next state so they are registered.
    busy_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
             (state_d == S_DATA_HI) || (state_d == S_DATA_LO) ||
             (state_d == S_CHECK);
    run_d  = (state_d == S_RUN);
    err_d  = (state_d == S_ERROR);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      chk_q     <= '0;
      hi_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      run_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      chk_q     <= chk_d;
      hi_q      <= hi_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      run_q     <= run_d;
      err_q     <= err_d;
    end
  end

  assign Wr_En   = wr_en_q;
  assign Wr_Addr = wr_addr_q;
  assign Wr_Data = wr_data_q;
  assign Busy    = busy_q;
  assign Cpu_Run = run_q;
  assign Error   = err_q;

endmodule
